dpram_arbiter: RTL

Two-requester arbiter that shares a single port of the 1024x16 `dpram` between two masters, e.g. the CPU load/store unit and an I/O/loader engine. It drives the RAM port (`en`, `addr`, `data`) and returns read data to the winning requester one cycle later. Arbitration is round-robin with a bounded burst: a requester may keep the port for up to `MAX_BURST` consecutive cycles while the other waits.

---
 rtl/dpram_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dpram_arbiter.sv
// dpram_arbiter: round-robin, burst-bounded arbiter sharing one dpram port
// between two requesters.
//   clk, reset                : clock, synchronous active-high reset
//   req*/we*/addr*/wdata*     : requester 0/1 access request and payload
//   gnt0/gnt1                 : combinational grant, access consumed at edge
//   rvalid*/rdata*            : read return, one cycle after a granted read
//   mem_en/mem_addr/mem_data  : RAM port A drive (en_A, addr_A, data_A)
//   mem_out                   : RAM port A registered read data (out_A)
module dpram_arbiter #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_out
);

    localparam int unsigned BURST_W = 4;
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0] BURST_SAT = {BURST_W{1'b1}};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0]         state, state_nxt;
    logic               last, last_nxt;
    logic [BURST_W-1:0] burst, burst_nxt;
    logic [1:0]         rd_pend, rd_pend_nxt;
    logic               win0, win1;

    // State register; reset clears everything and drops any pending read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            last    <= 1'b1;
            burst   <= '0;
            rd_pend <= '0;
        end else begin
            state   <= state_nxt;
            last    <= last_nxt;
            burst   <= burst_nxt;
            rd_pend <= rd_pend_nxt;
        end
    end

    // Grant decision and next-state computation.
    always_comb begin
        win0        = 1'b0;
        win1        = 1'b0;
        state_nxt   = IDLE;
        last_nxt    = last;
        burst_nxt   = '0;
        rd_pend_nxt = '0;

        if (req0 && !req1) begin
            win0 = 1'b1;
        end else if (req1 && !req0) begin
            win1 = 1'b1;
        end else if (req0 && req1) begin
            case (state)
                OWN0: begin
                    if (burst < BURST_MAX) win0 = 1'b1;
                    else                   win1 = 1'b1;
                end
                OWN1: begin
                    if (burst < BURST_MAX) win1 = 1'b1;
                    else                   win0 = 1'b1;
                end
                default: begin
                    // After an idle cycle the requester that did not win last goes first.
                    if (last) win0 = 1'b1;
                    else      win1 = 1'b1;
                end
            endcase
        end

        if (win0) begin
            state_nxt = OWN0;
            last_nxt  = 1'b0;
            if (state == OWN0) burst_nxt = (burst == BURST_SAT) ? burst : burst + BURST_W'(1);
            else               burst_nxt = BURST_W'(1);
        end else if (win1) begin
            state_nxt = OWN1;
            last_nxt  = 1'b1;
            if (state == OWN1) burst_nxt = (burst == BURST_SAT) ? burst : burst + BURST_W'(1);
            else               burst_nxt = BURST_W'(1);
        end

        rd_pend_nxt = {win1 & ~we1, win0 & ~we0};
    end

    // Port mux and read return; reset forces the RAM-side and grant outputs low.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        mem_en   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        rvalid0  = 1'b0;
        rvalid1  = 1'b0;
        rdata0   = '0;
        rdata1   = '0;
        if (!reset) begin
            gnt0     = win0;
            gnt1     = win1;
            mem_en   = (win0 & we0) | (win1 & we1);
            mem_addr = win1 ? addr1 : addr0;
            mem_data = win1 ? wdata1 : wdata0;
            rvalid0  = rd_pend[0];
            rvalid1  = rd_pend[1];
            if (rd_pend[0]) rdata0 = mem_out;
            if (rd_pend[1]) rdata1 = mem_out;
        end
    end

endmodule
